// File: rtl/lo_sle_serial_ctrl.sv
// rtl/lo_sle_serial_ctrl.sv - serial loader for the LO synthesizer: 32-bit word out on SCLK/SDATA, then an LE pulse
module lo_sle_serial_ctrl #(
    parameter int CLK_DIV   = 8,
    parameter int LE_CYCLES = 16
) (
    input  logic        user_clk,
    input  logic        rst_n,
    input  logic [31:0] cfg_word,
    input  logic        cfg_go,
    input  logic        err_clr,
    output logic        lo_sclk,
    output logic        lo_sdata,
    output logic        lo_le,
    output logic        busy,
    output logic [15:0] done_cnt,
    output logic        err_ovr
);

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, GAP} state_t;

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
    localparam logic [7:0] LE_M1  = 8'(LE_CYCLES - 1);

    state_t      state, state_nx;
    logic        go_q;
    logic        go_edge;
    logic [7:0]  phase, phase_nx;
    logic [4:0]  bit_cnt, bit_cnt_nx;
    logic [31:0] sreg, sreg_nx;
    logic        le_fall;

    assign go_edge = cfg_go & ~go_q;
    assign le_fall = (state == LATCH) && (state_nx == GAP);

    // Outputs decode straight from the state register so reset clears them without waiting for a clock.
    assign lo_sclk  = (state == SHIFT_HI);
    assign lo_sdata = ((state == SHIFT_LO) || (state == SHIFT_HI)) && sreg[31];
    assign lo_le    = (state == LATCH);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx   = state;
        phase_nx   = phase;
        bit_cnt_nx = bit_cnt;
        sreg_nx    = sreg;
        case (state)
            IDLE: begin
                if (go_edge) begin
                    sreg_nx    = cfg_word;
                    bit_cnt_nx = 5'd31;
                    phase_nx   = DIV_M1;
                    state_nx   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase == 8'd0) begin
                    phase_nx = DIV_M1;
                    state_nx = SHIFT_HI;
                end else begin
                    phase_nx = phase - 8'd1;
                end
            end
            SHIFT_HI: begin
                if (phase == 8'd0) begin
                    if (bit_cnt == 5'd0) begin
                        phase_nx = LE_M1;
                        state_nx = LATCH;
                    end else begin
                        // Next bit appears together with the falling SCLK edge.
                        sreg_nx    = {sreg[30:0], 1'b0};
                        bit_cnt_nx = bit_cnt - 5'd1;
                        phase_nx   = DIV_M1;
                        state_nx   = SHIFT_LO;
                    end
                end else begin
                    phase_nx = phase - 8'd1;
                end
            end
            LATCH: begin
                if (phase == 8'd0) begin
                    phase_nx = DIV_M1;
                    state_nx = GAP;
                end else begin
                    phase_nx = phase - 8'd1;
                end
            end
            GAP: begin
                if (phase == 8'd0) begin
                    state_nx = IDLE;
                end else begin
                    phase_nx = phase - 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            go_q    <= 1'b1;
            phase   <= 8'd0;
            bit_cnt <= 5'd0;
            sreg    <= 32'd0;
        end else begin
            state   <= state_nx;
            go_q    <= cfg_go;
            phase   <= phase_nx;
            bit_cnt <= bit_cnt_nx;
            sreg    <= sreg_nx;
        end
    end

    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= 16'd0;
            err_ovr  <= 1'b0;
        end else begin
            if (le_fall) begin
                done_cnt <= done_cnt + 16'd1;
            end
            // A new overrun outranks a simultaneous clear.
            if (go_edge && busy) begin
                err_ovr <= 1'b1;
            end else if (err_clr) begin
                err_ovr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lo_sle_serial_ctrl.sv
// tb/tb_lo_sle_serial_ctrl.sv - scoreboard bench for lo_sle_serial_ctrl
module tb_lo_sle_serial_ctrl;

    logic        user_clk;
    logic        rst_n;
    logic [31:0] cfg_word;
    logic        cfg_go;
    logic        err_clr;
    logic        lo_sclk;
    logic        lo_sdata;
    logic        lo_le;
    logic        busy;
    logic [15:0] done_cnt;
    logic        err_ovr;

    lo_sle_serial_ctrl #(.CLK_DIV(2), .LE_CYCLES(4)) dut (
        .user_clk (user_clk),
        .rst_n    (rst_n),
        .cfg_word (cfg_word),
        .cfg_go   (cfg_go),
        .err_clr  (err_clr),
        .lo_sclk  (lo_sclk),
        .lo_sdata (lo_sdata),
        .lo_le    (lo_le),
        .busy     (busy),
        .done_cnt (done_cnt),
        .err_ovr  (err_ovr)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          exp_bits[$];
    logic [15:0] exp_done = 16'd0;
    bit          abort = 1'b0;
    bit          force_on = 1'b0;
    int          busy_rises = 0;
    int          le_rises = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops expected bits on each SCLK rise and checks timing of every transfer.
    int   busy_len = 0;
    int   rise_cnt = 0;
    int   le_len = 0;
    int   last_rise = -1;
    logic p_busy = 1'b0, p_sclk = 1'b0, p_le = 1'b0;

    always @(posedge user_clk) begin
        #1;
        if (!rst_n) exp_done = 16'd0;
        if (force_on) exp_done = 16'hFFFE;
        if (busy && !p_busy) begin
            busy_len = 0; rise_cnt = 0; le_len = 0; last_rise = -1;
            busy_rises++;
        end
        if (busy) busy_len++;
        if (lo_le) begin
            le_len++;
            le_rises += (!p_le) ? 1 : 0;
            check("latch_lines", 32'({lo_sclk, lo_sdata}), 32'd0);
        end
        if (lo_sclk && !p_sclk) begin
            rise_cnt++;
            if (last_rise >= 0) check("sclk_period", busy_len - last_rise, 32'd4);
            last_rise = busy_len;
            if (exp_bits.size() == 0) check("bit_underflow", 32'd1, 32'd0);
            else check("sdata", 32'(lo_sdata), 32'(exp_bits.pop_front()));
        end
        if (!lo_le && p_le) begin
            exp_done = exp_done + 16'd1;
            check("le_width", le_len, 32'd4);
            check("done_cnt", 32'(done_cnt), 32'(exp_done));
        end
        if (!busy && p_busy && !abort) begin
            check("busy_len", busy_len, 32'd134);
            check("sclk_rises", rise_cnt, 32'd32);
            check("bits_left", exp_bits.size(), 32'd0);
        end
        p_busy = busy; p_sclk = lo_sclk; p_le = lo_le;
    end

    task automatic start(input logic [31:0] w, input bit hold);
        cfg_word = w;
        for (int i = 31; i >= 0; i--) exp_bits.push_back(w[i]);
        cfg_go = 1'b1;
        @(negedge user_clk);
        if (!hold) cfg_go = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge user_clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_le(input logic v, input int limit);
        int n = 0;
        while (lo_le !== v && n < limit) begin
            @(negedge user_clk);
            n++;
        end
        if (lo_le !== v) check("le_timeout", 32'(lo_le), 32'(v));
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge user_clk);
        err_clr = 1'b0;
    endtask

    initial begin
        int br;
        int lr;
        rst_n = 1'b0; cfg_go = 1'b0; err_clr = 1'b0; cfg_word = 32'd0;
        repeat (3) @(negedge user_clk);
        check("rst_sclk", 32'(lo_sclk), 32'd0);
        check("rst_sdata", 32'(lo_sdata), 32'd0);
        check("rst_le", 32'(lo_le), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done_cnt), 32'd0);
        check("rst_err", 32'(err_ovr), 32'd0);
        rst_n = 1'b1;
        @(negedge user_clk);

        start(32'hA5C3_0F01, 1'b0);
        check("busy_after_go", 32'(busy), 32'd1);
        wait_idle(300);
        check("done_one", 32'(done_cnt), 32'd1);
        check("err_clean", 32'(err_ovr), 32'd0);

        start(32'h1234_5678, 1'b0);
        repeat (48) @(negedge user_clk);
        cfg_go = 1'b1;
        @(negedge user_clk);
        cfg_go = 1'b0;
        wait_idle(300);
        check("ovr_set", 32'(err_ovr), 32'd1);
        check("ovr_done", 32'(done_cnt), 32'd2);
        pulse_clr();
        check("ovr_cleared", 32'(err_ovr), 32'd0);

        start(32'h8000_0001, 1'b0);
        repeat (20) @(negedge user_clk);
        cfg_go = 1'b1; err_clr = 1'b1;
        @(negedge user_clk);
        cfg_go = 1'b0; err_clr = 1'b0;
        check("set_wins", 32'(err_ovr), 32'd1);
        wait_idle(300);
        pulse_clr();

        start(32'h0F0F_00FF, 1'b0);
        repeat (9) @(negedge user_clk);
        cfg_word = 32'hFFFF_FFFF;
        wait_idle(300);

        start(32'h3C3C_3C3C, 1'b0);
        wait_le(1'b1, 300);
        wait_le(1'b0, 20);
        @(negedge user_clk);
        cfg_go = 1'b1;
        @(negedge user_clk);
        check("gap_exit_ovr", 32'(err_ovr), 32'd1);
        check("gap_exit_idle", 32'(busy), 32'd0);
        cfg_go = 1'b0;
        repeat (3) @(negedge user_clk);
        check("gap_exit_no_xfer", 32'(busy), 32'd0);
        pulse_clr();

        start(32'h5A5A_5A5A, 1'b0);
        wait_le(1'b1, 300);
        wait_le(1'b0, 20);
        repeat (2) @(negedge user_clk);
        start(32'hC001_D00D, 1'b0);
        check("idle_first_start", 32'(busy), 32'd1);
        check("idle_first_no_ovr", 32'(err_ovr), 32'd0);
        wait_idle(300);

        start(32'h1357_9BDF, 1'b0);
        repeat (69) @(negedge user_clk);
        abort = 1'b1;
        rst_n = 1'b0;
        #1;
        check("abort_sclk", 32'(lo_sclk), 32'd0);
        check("abort_sdata", 32'(lo_sdata), 32'd0);
        check("abort_le", 32'(lo_le), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done_cnt), 32'd0);
        lr = le_rises;
        repeat (3) @(negedge user_clk);
        rst_n = 1'b1;
        exp_bits.delete();
        abort = 1'b0;
        repeat (200) @(negedge user_clk);
        check("abort_no_le", le_rises, lr);
        check("abort_done_after", 32'(done_cnt), 32'd0);

        cfg_go = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge user_clk);
        rst_n = 1'b1;
        br = busy_rises;
        repeat (200) @(negedge user_clk);
        check("held_go_no_xfer", busy_rises, br);
        cfg_go = 1'b0;
        @(negedge user_clk);
        start(32'hDEAD_BEEF, 1'b1);
        wait_idle(300);
        repeat (200) @(negedge user_clk);
        check("held_go_one_xfer", busy_rises, br + 1);
        cfg_go = 1'b0;
        @(negedge user_clk);

        force dut.done_cnt = 16'hFFFE;
        force_on = 1'b1;
        @(negedge user_clk);
        release dut.done_cnt;
        force_on = 1'b0;
        @(negedge user_clk);
        check("preload", 32'(done_cnt), 32'hFFFE);
        start(32'h0000_0000, 1'b0);
        wait_idle(300);
        check("pre_wrap", 32'(done_cnt), 32'hFFFF);
        start(32'hFFFF_FFFF, 1'b0);
        wait_idle(300);
        check("wrap", 32'(done_cnt), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
